rom_share_arbiter: RTL

ROM_SHARE_ARBITER -- requirements
Module: rom_share_arbiter

---
 rtl/rom_arb_pkg.sv | 15 +
 rtl/rom_share_arbiter_rr_pick.sv | 34 +++
 rtl/rom_share_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// Shared constants and FSM state type for the image-ROM share arbiter.
package rom_arb_pkg;

  localparam int IMG_W   = 584;
  localparam int IMG_H   = 167;
  localparam int ROW_W   = 8;
  localparam int COL_W   = 10;
  localparam int COLOR_W = 12;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rom_share_arbiter_rr_pick.sv
// Round-robin picker: one-hot selection of the first set bit of req_i
// at or after index start_i, wrapping around.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [NREQ-1:0]  pick_o
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] back;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   prot;
  logic              found;

  // Rotate so start_i lands at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    dbl   = {req_i, req_i} >> start_i;
    rot   = dbl[NREQ-1:0];
    prot  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        prot[k] = 1'b1;
        found   = 1'b1;
      end
    end
    back   = {prot, prot} << start_i;
    pick_o = back[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/rom_share_arbiter.sv
// Shares one image ROM between NREQ requesters with burst-limited
// round-robin ownership. Read data returns two cycles after the grant.
// Optional macro ROM_ARB_BOUNDS_CHK_EN: out-of-image coordinates are not
// sent to the ROM and their read returns zero.
module rom_share_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MAX_BURST = 584
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ROW_W-1:0] req_row,
  input  logic [NREQ*COL_W-1:0] req_col,
  output logic [NREQ-1:0]       gnt,
  output logic [ROW_W-1:0]      rom_row,
  output logic [COL_W-1:0]      rom_col,
  input  logic [COLOR_W-1:0]    rom_color,
  output logic [NREQ-1:0]       rvalid,
  output logic [COLOR_W-1:0]    rdata
);

  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NREQ - 1);

  function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] c);
    return (c >= BURST_MAX) ? BURST_MAX : c + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] oh_to_idx(input logic [NREQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (oh[k]) idx = IDX_W'(k);
    end
    return idx;
  endfunction

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [IDX_W-1:0]     start_idx;
  logic [NREQ-1:0]      owner_oh;
  logic [NREQ-1:0]      others;
  logic [NREQ-1:0]      pick;
  logic [NREQ-1:0]      gnt_c;
  logic [ROW_W-1:0]     sel_row;
  logic [COL_W-1:0]     sel_col;
  logic                 oob_c;
  logic [ROW_W-1:0]     rom_row_q;
  logic [COL_W-1:0]     rom_col_q;
  logic [NREQ-1:0]      tag_p0_q, tag_p1_q;
  logic                 oob_p0_q, oob_p1_q;

  // Round-robin search always begins just after the current/last owner.
  always_comb begin
    start_idx = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    owner_oh  = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
    others    = req & ~owner_oh;
  end

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (req),
    .start_i (start_idx),
    .pick_o  (pick)
  );

  // Ownership FSM: next state, owner, burst count and the combinational grant.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    gnt_c       = '0;
    if (reset_n) begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_c       = pick;
            state_d     = OWN;
            owner_d     = oh_to_idx(pick);
            burst_cnt_d = BURST_W'(1);
          end
        end
        OWN: begin
          if (|(req & owner_oh) && (burst_cnt_q < BURST_MAX || others == '0)) begin
            gnt_c       = owner_oh;
            burst_cnt_d = sat_inc(burst_cnt_q);
          end else if (|others) begin
            gnt_c       = pick;
            owner_d     = oh_to_idx(pick);
            burst_cnt_d = BURST_W'(1);
          end else begin
            state_d     = IDLE;
            burst_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Mux the granted requester's coordinates and flag out-of-image reads.
  always_comb begin
    sel_row = '0;
    sel_col = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_c[k]) begin
        sel_row = req_row[k*ROW_W +: ROW_W];
        sel_col = req_col[k*COL_W +: COL_W];
      end
    end
`ifdef ROM_ARB_BOUNDS_CHK_EN
    oob_c = (sel_col >= COL_W'(IMG_W)) || (sel_row >= ROW_W'(IMG_H));
`else
    oob_c = 1'b0;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= LAST_IDX;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Stage p0: ROM address register, updated only on an in-bounds grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rom_row_q <= '0;
      rom_col_q <= '0;
    end else if (|gnt_c && !oob_c) begin
      rom_row_q <= sel_row;
      rom_col_q <= sel_col;
    end
  end

  // Stages p0/p1: owner tag follows the read while the ROM registers it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tag_p0_q <= '0;
      tag_p1_q <= '0;
    end else begin
      tag_p0_q <= gnt_c;
      tag_p1_q <= tag_p0_q;
    end
  end

  // Out-of-bounds flag travels with the tag; gated by the tag on output.
  always_ff @(posedge clk) begin
    oob_p0_q <= oob_c;
    oob_p1_q <= oob_p0_q;
  end

  assign gnt     = gnt_c;
  assign rom_row = rom_row_q;
  assign rom_col = rom_col_q;
  assign rvalid  = tag_p1_q;
  assign rdata   = (|tag_p1_q && !oob_p1_q) ? rom_color : '0;

endmodule
